mem_port_arbiter: RTL and testbench

Shares one single-port memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the pipelined CPU, building a unified-memory variant of the core. Arbitrates, latches the winning request, drives the memory port until the memory signals ready, then returns read data and a one-cycle acknowledge to the winner. The CPU holds its stage stalled while its request is outstanding.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF requester, data requester and the shared memory port.
// master = arbiter side, slave = requesters plus memory (the environment).
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_ack_o;
    logic [DW-1:0] if_rdata_o;

    logic          dm_req_i;
    logic          dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic          dm_ack_o;
    logic [DW-1:0] dm_rdata_o;

    logic          err_o;

    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_ready_i;

    modport master (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i, mem_ready_i,
        output if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o, err_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i, mem_ready_i,
        input  if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o, err_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the IF and data requesters (IDLE -> ACCESS -> RESP).
// Optional macro ARB_TIMEOUT_EN: abort an ACCESS after TIMEOUT_CYC cycles without ready, flagged on err_o.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_port_arbiter_if.master bus
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
    end
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYC must be 2..255");
    end

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        r_state,    w_state_next;
    logic          r_owner,    w_owner_next;     // 1 = data requester owns the port
    logic          r_we,       w_we_next;
    logic [AW-1:0] r_addr,     w_addr_next;
    logic [DW-1:0] r_wdata,    w_wdata_next;
    logic [3:0]    r_streak,   w_streak_next;
    logic [DW-1:0] r_if_rdata, w_if_rdata_next;
    logic [DW-1:0] r_dm_rdata, w_dm_rdata_next;
    logic          w_grant_dm;
    logic          w_access;
    logic          w_resp;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] r_wait, w_wait_next;
    logic       r_err,  w_err_next;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_streak   <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
            r_wait     <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_we       <= w_we_next;
            r_addr     <= w_addr_next;
            r_wdata    <= w_wdata_next;
            r_streak   <= w_streak_next;
            r_if_rdata <= w_if_rdata_next;
            r_dm_rdata <= w_dm_rdata_next;
`ifdef ARB_TIMEOUT_EN
            r_wait     <= w_wait_next;
            r_err      <= w_err_next;
`endif
        end
    end

    // Data wins contention unless IF has already been passed over STARVE_LIMIT times in a row.
    assign w_grant_dm = bus.dm_req_i && (!bus.if_req_i || (r_streak != LP_LIMIT));

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_we_next       = r_we;
        w_addr_next     = r_addr;
        w_wdata_next    = r_wdata;
        w_streak_next   = r_streak;
        w_if_rdata_next = r_if_rdata;
        w_dm_rdata_next = r_dm_rdata;
`ifdef ARB_TIMEOUT_EN
        w_wait_next     = r_wait;
        w_err_next      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.if_req_i || bus.dm_req_i) begin
                    w_state_next = ST_ACCESS;
                    w_owner_next = w_grant_dm;
`ifdef ARB_TIMEOUT_EN
                    w_wait_next  = '0;
`endif
                    if (w_grant_dm) begin
                        w_we_next    = bus.dm_we_i;
                        w_addr_next  = bus.dm_addr_i;
                        w_wdata_next = bus.dm_wdata_i;
                        if (bus.if_req_i) begin
                            w_streak_next = (r_streak == LP_LIMIT) ? r_streak : r_streak + 4'd1;
                        end else begin
                            w_streak_next = '0;
                        end
                    end else begin
                        w_we_next     = 1'b0;
                        w_addr_next   = bus.if_addr_i;
                        w_wdata_next  = '0;
                        w_streak_next = '0;
                    end
                end
            end
            ST_ACCESS: begin
`ifdef ARB_TIMEOUT_EN
                w_wait_next = r_wait + 8'd1;
`endif
                if (bus.mem_ready_i) begin
                    if (!r_we) begin
                        if (r_owner) w_dm_rdata_next = bus.mem_rdata_i;
                        else         w_if_rdata_next = bus.mem_rdata_i;
                    end
                    w_state_next = ST_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_wait == LP_TO_LAST) begin
                    if (r_owner) w_dm_rdata_next = '0;
                    else         w_if_rdata_next = '0;
                    w_err_next   = 1'b1;
                    w_state_next = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Memory port is driven only from the latched request, and only while in ACCESS.
    assign w_access        = (r_state == ST_ACCESS);
    assign w_resp          = (r_state == ST_RESP);
    assign bus.mem_en_o    = w_access;
    assign bus.mem_we_o    = w_access && r_we;
    assign bus.mem_addr_o  = w_access ? r_addr  : '0;
    assign bus.mem_wdata_o = w_access ? r_wdata : '0;

    assign bus.if_ack_o    = w_resp && !r_owner;
    assign bus.dm_ack_o    = w_resp && r_owner;
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.dm_rdata_o  = r_dm_rdata;

`ifdef ARB_TIMEOUT_EN
    assign bus.err_o       = w_resp && r_err;
`else
    assign bus.err_o       = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then a random request stream against a transaction-level model.
// The bench plays both requesters and the memory; expected grants come from the arbitration rules.
module tb_mem_port_arbiter;
    localparam int STARVE = 4;
    localparam int TO_CYC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus_if ();

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(STARVE), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          model_streak = 0;
    int          txn_id = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dm_rdata = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},     {31'd0, bus_if.mem_en_o}, 32'd0);
        chk({tag, "_we"},     {31'd0, bus_if.mem_we_o}, 32'd0);
        chk({tag, "_addr"},   bus_if.mem_addr_o, 32'd0);
        chk({tag, "_wdata"},  bus_if.mem_wdata_o, 32'd0);
        chk({tag, "_acks"},   {29'd0, bus_if.if_ack_o, bus_if.dm_ack_o, bus_if.err_o}, 32'd0);
        chk({tag, "_ifrd"},   bus_if.if_rdata_o, 32'd0);
        chk({tag, "_dmrd"},   bus_if.dm_rdata_o, 32'd0);
    endtask

    // Called in an IDLE cycle with requests already on the bus; returns in the following IDLE cycle.
    // who: 0 = IF granted, 1 = data granted, 2 = no request.
    task automatic run_txn(input int lat, input bit perturb, output int who);
        logic [31:0] a, wd;
        bit          we, ifr, dmr, win_dm;
        ifr = bus_if.if_req_i;
        dmr = bus_if.dm_req_i;
        chk("idle_en", {31'd0, bus_if.mem_en_o}, 32'd0);
        if (!ifr && !dmr) begin
            who = 2;
            tick();
            return;
        end
        win_dm = dmr && !(ifr && model_streak == STARVE);
        if (win_dm && ifr) model_streak = (model_streak < STARVE) ? model_streak + 1 : STARVE;
        else               model_streak = 0;
        who = win_dm ? 1 : 0;
        a   = win_dm ? bus_if.dm_addr_i : bus_if.if_addr_i;
        we  = win_dm && bus_if.dm_we_i;
        wd  = bus_if.dm_wdata_i;
        tick();
        for (int k = 0; k <= lat; k++) begin
            chk("access_en",   {31'd0, bus_if.mem_en_o}, 32'd1);
            chk("access_addr", bus_if.mem_addr_o, a);
            chk("access_we",   {31'd0, bus_if.mem_we_o}, {31'd0, we});
            if (we) chk("access_wdata", bus_if.mem_wdata_o, wd);
            chk("access_no_ack", {30'd0, bus_if.if_ack_o, bus_if.dm_ack_o}, 32'd0);
            if (perturb && k == 0) begin
                bus_if.if_addr_i  = 32'h40;
                bus_if.dm_addr_i  = 32'h40;
                bus_if.dm_we_i    = ~bus_if.dm_we_i;
                bus_if.dm_wdata_i = $urandom;
            end
            bus_if.mem_ready_i = (k == lat);
            bus_if.mem_rdata_i = we ? $urandom : ref_mem[idx(a)];
            tick();
        end
        if (we)          ref_mem[idx(a)] = wd;
        else if (win_dm) exp_dm_rdata = ref_mem[idx(a)];
        else             exp_if_rdata = ref_mem[idx(a)];
        chk("resp_if_ack", {31'd0, bus_if.if_ack_o}, {31'd0, !win_dm});
        chk("resp_dm_ack", {31'd0, bus_if.dm_ack_o}, {31'd0, win_dm});
        chk("resp_err",    {31'd0, bus_if.err_o}, 32'd0);
        chk("resp_en",     {30'd0, bus_if.mem_en_o, bus_if.mem_we_o}, 32'd0);
        chk("resp_if_rdata", bus_if.if_rdata_o, exp_if_rdata);
        chk("resp_dm_rdata", bus_if.dm_rdata_o, exp_dm_rdata);
        $display("txn %0d: %s %s addr=%h wait=%0d if_rdata=%h dm_rdata=%h", txn_id,
                 win_dm ? "DM" : "IF", we ? "WR" : "RD", a, lat, bus_if.if_rdata_o, bus_if.dm_rdata_o);
        txn_id++;
        // Ready outside ACCESS must have no effect.
        bus_if.mem_ready_i = 1'($urandom_range(0, 1));
        bus_if.mem_rdata_i = $urandom;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired=1 required=0");
        $fatal(1, "watchdog");
    end

    initial begin
        int       who;
        logic [5:0] order;

        bus_if.if_req_i    = 1'b0;
        bus_if.if_addr_i   = '0;
        bus_if.dm_req_i    = 1'b0;
        bus_if.dm_we_i     = 1'b0;
        bus_if.dm_addr_i   = '0;
        bus_if.dm_wdata_i  = '0;
        bus_if.mem_rdata_i = '0;
        bus_if.mem_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'h8C01_0000;

        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // IF read at 0x10, ready in the first ACCESS cycle
        bus_if.if_req_i  = 1'b1;
        bus_if.if_addr_i = 32'h10;
        run_txn(0, 1'b0, who);
        chk("tp_if_read_data", bus_if.if_rdata_o, 32'h8C01_0000);
        bus_if.if_req_i = 1'b0;

        // Data write with three wait cycles; dm_rdata must keep its value
        bus_if.dm_req_i   = 1'b1;
        bus_if.dm_we_i    = 1'b1;
        bus_if.dm_addr_i  = 32'h20;
        bus_if.dm_wdata_i = 32'hDEAD_BEEF;
        run_txn(3, 1'b0, who);
        chk("tp_write_dmrd_held", bus_if.dm_rdata_o, 32'd0);
        bus_if.dm_req_i = 1'b0;
        bus_if.dm_we_i  = 1'b0;

        // Read back the written word through the IF port
        bus_if.if_req_i  = 1'b1;
        bus_if.if_addr_i = 32'h20;
        run_txn(1, 1'b0, who);
        chk("tp_readback", bus_if.if_rdata_o, 32'hDEAD_BEEF);
        bus_if.if_req_i = 1'b0;

        // Requester address changes mid-ACCESS are ignored
        bus_if.if_req_i  = 1'b1;
        bus_if.if_addr_i = 32'h10;
        run_txn(2, 1'b1, who);
        chk("tp_perturb_data", bus_if.if_rdata_o, 32'h8C01_0000);
        bus_if.if_req_i = 1'b0;

        // Contention with both requests held high
        bus_if.dm_req_i  = 1'b1;
        bus_if.dm_we_i   = 1'b0;
        bus_if.dm_addr_i = 32'h08;
        bus_if.if_req_i  = 1'b1;
        bus_if.if_addr_i = 32'h0C;
        order = '0;
        for (int i = 0; i < 6; i++) begin
            run_txn(0, 1'b0, who);
            order[i] = (who == 1);
        end
        chk("starve_order", {26'd0, order}, 32'b101111);
        bus_if.dm_req_i = 1'b0;
        bus_if.if_req_i = 1'b0;
        tick();

        // Reset in the second ACCESS cycle abandons the access
        bus_if.dm_req_i  = 1'b1;
        bus_if.dm_addr_i = 32'h04;
        bus_if.mem_ready_i = 1'b0;
        tick();
        chk("rst_mid_en", {31'd0, bus_if.mem_en_o}, 32'd1);
        tick();
        rst = 1'b1;
        bus_if.dm_req_i = 1'b0;
        tick();
        chk_all_zero("rst_mid");
        rst = 1'b0;
        model_streak = 0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        tick();
        chk("rst_mid_no_ack", {29'd0, bus_if.if_ack_o, bus_if.dm_ack_o, bus_if.mem_en_o}, 32'd0);

        // Memory never ready
        bus_if.if_req_i  = 1'b1;
        bus_if.if_addr_i = 32'h10;
        run_txn(0, 1'b0, who);
        bus_if.if_addr_i   = 32'h14;
        bus_if.mem_ready_i = 1'b0;
        model_streak = 0;
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= TO_CYC; c++) begin
            tick();
            chk("to_wait_en",  {31'd0, bus_if.mem_en_o}, 32'd1);
            chk("to_wait_ack", {29'd0, bus_if.if_ack_o, bus_if.dm_ack_o, bus_if.err_o}, 32'd0);
        end
        tick();
        chk("to_if_ack", {31'd0, bus_if.if_ack_o}, 32'd1);
        chk("to_err",    {31'd0, bus_if.err_o}, 32'd1);
        chk("to_rdata",  bus_if.if_rdata_o, 32'd0);
        exp_if_rdata = '0;
        bus_if.if_req_i = 1'b0;
        tick();
        chk("to_after_err", {31'd0, bus_if.err_o}, 32'd0);
`else
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("no_to_ack", {29'd0, bus_if.if_ack_o, bus_if.dm_ack_o, bus_if.err_o}, 32'd0);
        end
        chk("no_to_en", {31'd0, bus_if.mem_en_o}, 32'd1);
        bus_if.if_req_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_streak = 0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        tick();
`endif

        // Random request stream
        who = 2;
        for (int t = 0; t < 80; t++) begin
            if (who == 0 || !bus_if.if_req_i) begin
                bus_if.if_req_i  = ($urandom_range(0, 3) != 0);
                bus_if.if_addr_i = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (who == 1 || !bus_if.dm_req_i) begin
                bus_if.dm_req_i   = ($urandom_range(0, 3) != 0);
                bus_if.dm_we_i    = 1'($urandom_range(0, 1));
                bus_if.dm_addr_i  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                bus_if.dm_wdata_i = $urandom;
            end
            run_txn($urandom_range(0, 3), 1'b0, who);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
